// File: rtl/serial_bit_tx_if.sv
// serial_bit_tx_if: word handshake in, serial line and frame status out.
interface serial_bit_tx_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   logic tx_out;
   logic tx_busy;
   logic tx_done;
   modport master (output tx_data, tx_valid, input tx_ready, tx_out, tx_busy, tx_done);
   modport slave (input tx_data, tx_valid, output tx_ready, tx_out, tx_busy, tx_done);
endinterface

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: sends one start(0) / LSB-first data / stop(1) frame per accepted word.
module serial_bit_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input logic           clk,
   input logic           reset,
   serial_bit_tx_if.slave bus
);
   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam int IW = $clog2(DATA_W + 1);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
   logic [1:0] state;
   logic [TW-1:0] timer;
   logic [IW-1:0] idx;
   logic [DATA_W-1:0] sh;
   logic out_r, ready_r, busy_r, done_r;
   logic bit_end;
   assign bit_end = timer == T_LAST;
   assign bus.tx_out = out_r;
   assign bus.tx_ready = ready_r;
   assign bus.tx_busy = busy_r;
   assign bus.tx_done = done_r;
   // Each bit is loaded into out_r on the edge that ends the previous bit, so the line is registered.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         timer <= '0;
         idx <= '0;
         sh <= '0;
         out_r <= 1'b1;
         ready_r <= 1'b1;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         timer <= (state == IDLE || bit_end) ? '0 : timer + 1'b1;
         case (state)
            IDLE: if (bus.tx_valid && ready_r) begin
               state <= START;
               sh <= bus.tx_data;
               out_r <= 1'b0;
               ready_r <= 1'b0;
               busy_r <= 1'b1;
            end
            START: if (bit_end) begin
               state <= DATA;
               idx <= '0;
               out_r <= sh[0];
               sh <= sh >> 1;
            end
            DATA: if (bit_end) begin
               if (idx == I_LAST) begin
                  state <= STOP;
                  out_r <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
                  out_r <= sh[0];
                  sh <= sh >> 1;
               end
            end
            default: if (bit_end) begin
               state <= IDLE;
               ready_r <= 1'b1;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         endcase
      end
endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: directed frames on a CLKS_PER_BIT=4 and a CLKS_PER_BIT=1 instance.
module tb_serial_bit_tx;
   logic clk = 1'b0, clk_en = 1'b0, reset = 1'b0;
   int checks = 0, failures = 0;
   logic [7:0] sb[$];

   serial_bit_tx_if #(.DATA_W(8)) b4 ();
   serial_bit_tx_if #(.DATA_W(8)) b1 ();
   serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
   serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

   always #5 if (clk_en) clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {tx_out, tx_ready, tx_busy, tx_done}
   function automatic logic [3:0] ctl(input int cpb);
      return cpb == 1 ? {b1.tx_out, b1.tx_ready, b1.tx_busy, b1.tx_done}
                      : {b4.tx_out, b4.tx_ready, b4.tx_busy, b4.tx_done};
   endfunction

   task automatic drive(input int cpb, input logic [7:0] d, input logic v);
      if (cpb == 1) begin
         b1.tx_data = d;
         b1.tx_valid = v;
      end else begin
         b4.tx_data = d;
         b4.tx_valid = v;
      end
   endtask

   task automatic send(input int cpb, input logic [7:0] w);
      sb.push_back(w);
      drive(cpb, w, 1'b1);
   endtask

   task automatic run_frame(input int cpb, input bit hold, input int chg_at,
                            input logic [7:0] chg_data, input int rst_at);
      logic [7:0] w;
      logic [79:0] obs, exp;
      logic [3:0] c4;
      logic eb;
      int k, bad;
      w = sb.pop_front();
      obs = '0;
      exp = '0;
      bad = 0;
      for (int c = 0; c < 10 * cpb; c++) begin
         @(negedge clk);
         k = c / cpb;
         eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : w[k-1];
         exp[c] = eb;
         c4 = ctl(cpb);
         obs[c] = c4[3];
         if (c4[2:0] != 3'b010) bad++;
         if (c == 0 && !hold) drive(cpb, chg_at >= 0 ? w : 8'h00, 1'b0);
         if (c == chg_at) drive(cpb, chg_data, 1'b1);
         if (c == chg_at + cpb && !hold) drive(cpb, chg_data, 1'b0);
         if (c == rst_at) begin
            reset = 1'b1;
            #1;
            chk("reset_async_midframe", ctl(cpb), 4'b1100);
            return;
         end
      end
      chk("frame_bits", obs, exp);
      chk("frame_ctrl_bad_cycles", bad, 0);
      @(negedge clk);
      chk("done_pulse", ctl(cpb), 4'b1101);
      if (!hold) begin
         @(negedge clk);
         chk("done_clear", ctl(cpb), 4'b1100);
      end
   endtask

   initial begin
      int bad;
      drive(4, 8'h00, 1'b0);
      drive(1, 8'h00, 1'b0);
      // Clock stopped: reset must act without any edge.
      #1 reset = 1'b1;
      #1 chk("reset_noclk_cpb4", ctl(4), 4'b1100);
      chk("reset_noclk_cpb1", ctl(1), 4'b1100);
      clk_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (ctl(4) != 4'b1100) bad++;
      end
      chk("idle_quiet", bad, 0);
      reset = 1'b1;
      #1 chk("reset_mididle", ctl(4), 4'b1100);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send(4, 8'hA5);
      run_frame(4, 1'b0, -1, 8'h00, -1);
      send(4, 8'h00);
      sb.push_back(8'hFF);
      run_frame(4, 1'b1, 2, 8'hFF, -1);
      run_frame(4, 1'b0, -1, 8'h00, -1);
      send(4, 8'hC3);
      run_frame(4, 1'b0, 12, 8'h3C, -1);
      send(4, 8'h96);
      run_frame(4, 1'b0, -1, 8'h00, 17);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (ctl(4) != 4'b1100) bad++;
      end
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (ctl(4) != 4'b1100) bad++;
      end
      chk("post_reset_no_done", bad, 0);
      send(4, 8'h5A);
      run_frame(4, 1'b0, -1, 8'h00, -1);
      send(1, 8'h01);
      run_frame(1, 1'b0, -1, 8'h00, -1);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
